// File: rtl/trafficlight_timer_if.sv
// rtl/trafficlight_timer_if.sv - controller-facing signal bundle of the traffic-light timer
interface trafficlight_timer_if;
    logic       cntr_reset;
    logic [2:0] rgb;
    logic       btn_raw;
    logic       tick;
    logic       btn;
    logic       expired;

    modport master (
        output cntr_reset, rgb, btn_raw,
        input  tick, btn, expired
    );

    modport slave (
        input  cntr_reset, rgb, btn_raw,
        output tick, btn, expired
    );
endinterface

// File: rtl/trafficlight_timer.sv
// rtl/trafficlight_timer.sv - prescaled per-light phase timer plus pushbutton synchroniser/debouncer
module trafficlight_timer #(
    parameter int PRESCALE = 1000,
    parameter int T_RED    = 8,
    parameter int T_YELLOW = 2,
    parameter int T_GREEN  = 6,
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                res,
    trafficlight_timer_if.slave bus
);
    // A zero-length phase would never expire, so it is stretched to one unit.
    localparam logic [CNT_W-1:0] L_RED    = (T_RED    < 1) ? CNT_W'(1) : CNT_W'(T_RED);
    localparam logic [CNT_W-1:0] L_YELLOW = (T_YELLOW < 1) ? CNT_W'(1) : CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] L_GREEN  = (T_GREEN  < 1) ? CNT_W'(1) : CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] L_PRE_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] L_DB_MAX  = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {S_COUNTING, S_EXPIRED} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] r_unit;
    logic [CNT_W-1:0] r_target;
    logic             r_tick;
    logic             r_expired;
    logic [CNT_W-1:0] w_sel_target;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_btn;

    always_comb begin
        w_sel_target = L_RED;
        case (bus.rgb)
            3'b100:  w_sel_target = L_RED;
            3'b110:  w_sel_target = L_YELLOW;
            3'b010:  w_sel_target = L_GREEN;
            default: w_sel_target = L_RED;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state   <= S_COUNTING;
            r_pre     <= '0;
            r_unit    <= '0;
            r_target  <= L_RED;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
        end else if (bus.cntr_reset) begin
            r_state   <= S_COUNTING;
            r_pre     <= '0;
            r_unit    <= '0;
            r_target  <= w_sel_target;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_COUNTING: begin
                    if (r_pre == L_PRE_MAX) begin
                        r_pre <= '0;
                        if (r_unit == r_target - CNT_W'(1)) begin
                            r_unit    <= '0;
                            r_tick    <= 1'b1;
                            r_expired <= 1'b1;
                            r_state   <= S_EXPIRED;
                        end else begin
                            r_unit <= r_unit + CNT_W'(1);
                        end
                    end else begin
                        r_pre <= r_pre + CNT_W'(1);
                    end
                end
                S_EXPIRED: begin
                    r_pre  <= '0;
                    r_unit <= '0;
                end
                default: r_state <= S_COUNTING;
            endcase
        end
    end

    // Only a sustained mismatch between the synchronised input and the accepted level moves the level.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_dcnt  <= '0;
            r_btn   <= 1'b0;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
            r_btn   <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_dcnt == L_DB_MAX) begin
                    r_level <= r_sync2;
                    r_dcnt  <= '0;
                    r_btn   <= r_sync2;
                end else begin
                    r_dcnt <= r_dcnt + CNT_W'(1);
                end
            end else begin
                r_dcnt <= '0;
            end
        end
    end

    assign bus.tick    = r_tick;
    assign bus.btn     = r_btn;
    assign bus.expired = r_expired;
endmodule

// File: tb/tb_trafficlight_timer.sv
// tb/tb_trafficlight_timer.sv - self-checking bench for trafficlight_timer
module tb_trafficlight_timer;
    localparam int P  = 4;
    localparam int TR = 3;
    localparam int TY = 2;
    localparam int TG = 6;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    trafficlight_timer_if bus();

    trafficlight_timer #(
        .PRESCALE(P), .T_RED(TR), .T_YELLOW(TY), .T_GREEN(TG), .DEBOUNCE(D), .CNT_W(16)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int btn_count  = 0;
    int tick_count = 0;

    // Reference: elapsed edges since the last restart against the latched interval length,
    // and a history of the last D synchronised samples for the button.
    int   m_elapsed;
    int   m_len;
    logic m_tick, m_btn, m_expired;
    logic m_r1, m_r2, m_level;
    logic m_hist[$];

    typedef struct {
        logic [2:0] rgb;
        int         cycles;
    } vec_t;
    vec_t vecs[6];

    function automatic int tsel(input logic [2:0] c);
        int t;
        case (c)
            3'b100:  t = TR;
            3'b110:  t = TY;
            3'b010:  t = TG;
            default: t = TR;
        endcase
        return (t < 1) ? 1 : t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_elapsed = 0;
        m_len     = P * tsel(3'b100);
        m_tick    = 1'b0;
        m_expired = 1'b0;
        m_btn     = 1'b0;
        m_r1      = 1'b0;
        m_r2      = 1'b0;
        m_level   = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_edge();
        logic s;
        bit   all_diff;
        if (res) begin
            model_reset();
            return;
        end
        if (bus.cntr_reset) begin
            m_elapsed = 0;
            m_len     = P * tsel(bus.rgb);
            m_tick    = 1'b0;
            m_expired = 1'b0;
        end else begin
            if (m_elapsed < 1000000) m_elapsed++;
            m_tick    = (m_elapsed == m_len);
            m_expired = (m_elapsed >= m_len);
        end
        s    = m_r2;
        m_r2 = m_r1;
        m_r1 = bus.btn_raw;
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        m_btn = 1'b0;
        if (m_hist.size() == D) begin
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] == m_level) all_diff = 1'b0;
            if (all_diff) begin
                m_level = s;
                m_btn   = s;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", bus.tick, m_tick);
        check("btn", bus.btn, m_btn);
        check("expired", bus.expired, m_expired);
        if (bus.btn)  btn_count++;
        if (bus.tick) tick_count++;
    endtask

    task automatic wait_tick(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick && n < 200);
        check(name, n, exp_n);
    endtask

    task automatic restart(input logic [2:0] c);
        bus.rgb        = c;
        bus.cntr_reset = 1'b1;
        step();
        bus.cntr_reset = 1'b0;
    endtask

    initial begin
        int n;
        int pat[12];
        vecs[0] = '{3'b100, P*TR};
        vecs[1] = '{3'b010, P*TG};
        vecs[2] = '{3'b110, P*TY};
        vecs[3] = '{3'b111, P*TR};
        vecs[4] = '{3'b000, P*TR};
        vecs[5] = '{3'b011, P*TR};
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

        res = 1'b1;
        bus.cntr_reset = 1'b0;
        bus.rgb        = 3'b100;
        bus.btn_raw    = 1'b0;
        model_reset();
        step();
        step();
        check("reset_tick", bus.tick, 0);
        check("reset_btn", bus.btn, 0);
        check("reset_expired", bus.expired, 0);
        res = 1'b0;
        wait_tick("reset_default_interval", P*TR);
        check("expired_after_tick", bus.expired, 1);

        for (int i = 0; i < 6; i++) begin
            restart(vecs[i].rgb);
            bus.rgb = 3'($urandom);
            wait_tick($sformatf("interval_rgb%0b", vecs[i].rgb), vecs[i].cycles);
            check("expired_level", bus.expired, 1);
            tick_count = 0;
            repeat (30) step();
            check("no_repeat_tick", tick_count, 0);
        end

        restart(3'b100);
        repeat (P*TR - 1) step();
        bus.cntr_reset = 1'b1;
        step();
        check("collision_no_tick", bus.tick, 0);
        bus.cntr_reset = 1'b0;
        wait_tick("after_collision", P*TR);

        bus.cntr_reset = 1'b1;
        bus.rgb = 3'b010;
        step();
        step();
        bus.rgb = 3'b110;
        step();
        bus.cntr_reset = 1'b0;
        wait_tick("held_restart_last_wins", P*TY);

        btn_count = 0;
        bus.btn_raw = 1'b1;
        repeat (3) step();
        bus.btn_raw = 1'b0;
        repeat (12) step();
        check("short_press_no_btn", btn_count, 0);

        bus.btn_raw = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.btn && n < 50);
        check("btn_latency", n, D + 2);
        repeat (20) step();
        check("held_single_pulse", btn_count, 1);
        bus.btn_raw = 1'b0;
        btn_count = 0;
        repeat (15) step();
        check("release_no_pulse", btn_count, 0);

        for (int k = 0; k < 12; k++) begin
            bus.btn_raw = pat[k][0];
            step();
        end
        repeat (10) step();
        check("bounce_single_pulse", btn_count, 1);
        bus.btn_raw = 1'b0;
        repeat (12) step();

        restart(3'b100);
        wait_tick("pre_reset_interval", P*TR);
        bus.btn_raw = 1'b1;
        repeat (3) step();
        check("pre_reset_expired", bus.expired, 1);
        #2 res = 1'b1;
        model_reset();
        #1;
        check("async_reset_tick", bus.tick, 0);
        check("async_reset_btn", bus.btn, 0);
        check("async_reset_expired", bus.expired, 0);
        #2 res = 1'b0;
        wait_tick("post_reset_interval", P*TR);
        bus.btn_raw = 1'b0;

        for (int c = 0; c < 800; c++) begin
            bus.cntr_reset = ($urandom_range(0, 19) == 0);
            bus.rgb        = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) bus.btn_raw = ~bus.btn_raw;
            step();
            if ($urandom_range(0, 299) == 0) begin
                #2 res = 1'b1;
                model_reset();
                #1 res = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
